lfsr4_checker: RTL
==================

LFSR4_CHECKER -- requirements
Module: lfsr4_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4: consecutive matching words needed to declare lock (range 1..15).
REQ-002 SHALL have parameter LOSS_THR, default 3: consecutive mismatching words that drop lock (range 1..15).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port din_valid, input, 1: din holds a received word this cycle.
REQ-006 SHALL have port din, input, 4: received 4-bit LFSR state word.
REQ-007 SHALL have port mod, input, 3: mod[0] selects the polynomial, mod[1] selects inverted data, mod[2] is reserved and ignored.
REQ-008 SHALL have port locked, output, 1: high while in LOCKED.
REQ-009 SHALL have port err_pulse, output, 1: one-cycle pulse for each mismatch while LOCKED.
REQ-010 SHALL have port lost_pulse, output, 1: one-cycle pulse when lock is dropped.
REQ-011 SHALL have port err_cnt, output, 8: saturating count of mismatches while LOCKED.
REQ-012 SHALL have port word_cnt, output, 16: count of words checked while LOCKED (see Configuration).

Function
REQ-013 SHALL compute next(s) = {s[2:0], fb}.
- mod[0]=0: fb = s[3]^s[2].
- mod[0]=1: fb = s[3]^s[0].
- Both polynomials give period 15 and exclude 0000.
REQ-014 SHALL form the effective word w = din ^ {4{mod[1]}}; all comparisons use w.
REQ-015 SHALL ignore din when din_valid=0: state, predictor and counters hold; pulses stay low.
REQ-016 SHALL implement four states: SEARCH, VERIFY, LOCKED, LOST.
REQ-017 SEARCH:
- valid w != 0000: predictor <= next(w), match count <= 0, go to VERIFY.
- w = 0000: ignored.
REQ-018 VERIFY, valid w:
- w == predictor: match count increments; predictor <= next(predictor).
- Match count reaching LOCK_CNT: go to LOCKED.
- Mismatch with w != 0: reseed (predictor <= next(w)), match count <= 0.
- w = 0000: go to SEARCH.
REQ-019 LOCKED, valid w:
- predictor <= next(predictor) always; the predictor free-runs and is never reseeded.
- Mismatch: err_pulse=1, err_cnt increments with saturation at 255, miss run increments.
- Match: miss run <= 0.
REQ-020 LOCKED: when the miss run reaches LOSS_THR, go to LOST.
REQ-021 LOST lasts exactly one cycle:
- lost_pulse=1.
- Then go to SEARCH regardless of din_valid.
- err_cnt retained.
REQ-022 Any change of mod[1:0] between consecutive cycles SHALL force SEARCH next cycle.
- No lost_pulse is generated by this.
- This rule takes priority over all other transitions.
REQ-023 All outputs SHALL be registered; the response to a word accepted at edge N is visible after edge N+1.
REQ-024 err_cnt SHALL clear only on reset; reacquiring lock does not clear it.

Reset
REQ-025 Reset SHALL set:
- state = SEARCH;
- predictor = 0001;
- match count, miss run and mod history = 0;
- locked, err_pulse, lost_pulse, err_cnt and word_cnt = 0.
REQ-026 Reset asserted mid-operation SHALL abandon lock immediately, with no lost_pulse.

Configuration
REQ-027 With macro LFSR4_CHECKER_WORDCNT_EN defined:
- word_cnt increments for every valid word checked in LOCKED, wrapping at 65535.
- word_cnt clears only on reset.
REQ-028 Without LFSR4_CHECKER_WORDCNT_EN: word_cnt SHALL be a constant 0 and no counter flops are present.

Structure
REQ-029 Package lfsr4_pkg SHALL hold:
- the state enum;
- the constants POLY_A_SEL=0 and POLY_B_SEL=1;
- the default values of LOCK_CNT and LOSS_THR.
REQ-030 Sub-module lfsr4_step SHALL hold the combinational next() function (inputs s[3:0] and poly select), instantiated for both seeding and prediction.

Verification
REQ-031 Clean stream, mod=000, words 0001,0010,0100,1001,0011,0110 on consecutive cycles -> locked=1 one cycle after the fifth word; err_cnt=0.
REQ-032 Locked on poly B (mod=001, words 0001,0011,0111,1111,1110), then one corrupted word -> err_pulse one cycle; err_cnt=1; locked stays 1.
REQ-033 Locked, then three consecutive wrong words with LOSS_THR=3 -> lost_pulse one cycle; locked=0; state SEARCH; err_cnt=3.
REQ-034 mod=010, inverted stream 1110,1101,1011,0110,1100 -> locks; then toggling mod[1] -> locked=0 next cycle, with no lost_pulse.
REQ-035 Locked with 260 mismatches injected, each separated by good words -> err_cnt saturates at 255.
- With LFSR4_CHECKER_WORDCNT_EN defined, word_cnt equals the number of words checked in LOCKED.
- Reset pulse mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/lfsr4_pkg.sv
// Shared types and constants for the 4-bit LFSR stream checker.
package lfsr4_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2,
    LOST   = 2'd3
  } state_e;

  localparam logic POLY_A_SEL = 1'b0;  // fb = s[3] ^ s[2]
  localparam logic POLY_B_SEL = 1'b1;  // fb = s[3] ^ s[0]

  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_LOSS_THR = 3;

endpackage

// File: rtl/lfsr4_step.sv
// One combinational step of the 4-bit LFSR: next(s) = {s[2:0], fb}.
module lfsr4_step
  import lfsr4_pkg::*;
(
  input  logic [3:0] s,
  input  logic       poly_sel,
  output logic [3:0] s_next
);

  logic fb;

  assign fb     = (poly_sel == POLY_B_SEL) ? (s[3] ^ s[0]) : (s[3] ^ s[2]);
  assign s_next = {s[2:0], fb};

endmodule

// File: rtl/lfsr4_checker.sv
// LFSR4 stream checker: acquires lock on a 4-bit LFSR word stream and counts errors.
// Optional word counter enabled by defining LFSR4_CHECKER_WORDCNT_EN.
module lfsr4_checker
  import lfsr4_pkg::*;
#(
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int LOSS_THR = DEF_LOSS_THR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din_valid,
  input  logic [3:0]  din,
  input  logic [2:0]  mod,
  output logic        locked,
  output logic        err_pulse,
  output logic        lost_pulse,
  output logic [7:0]  err_cnt,
  output logic [15:0] word_cnt
);

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_LIM = 4'(LOSS_THR);

  // Input stage: words are sampled here and judged on the following edge.
  logic       in_valid;
  logic [3:0] in_din;
  logic [1:0] in_mod;
  logic [1:0] mod_hist;
  logic       unused_mod_bit;

  state_e     state, state_d;
  logic [3:0] predictor, pred_d;
  logic [3:0] match_cnt, match_d;
  logic [3:0] miss_run, miss_d;
  logic       err_d;

  logic [3:0] w, seed_next, pred_next, match_inc, miss_inc;
  logic       mod_change, match;

  assign unused_mod_bit = mod[2];

  assign w          = in_din ^ {4{in_mod[1]}};
  assign match      = (w == predictor);
  assign mod_change = (in_mod != mod_hist);
  assign match_inc  = match_cnt + 4'd1;
  assign miss_inc   = miss_run + 4'd1;

  lfsr4_step u_seed_step (.s(w),         .poly_sel(in_mod[0]), .s_next(seed_next));
  lfsr4_step u_pred_step (.s(predictor), .poly_sel(in_mod[0]), .s_next(pred_next));

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state;
    pred_d  = predictor;
    match_d = match_cnt;
    miss_d  = miss_run;
    err_d   = 1'b0;
    if (mod_change) begin
      state_d = SEARCH;
      match_d = '0;
      miss_d  = '0;
    end else begin
      case (state)
        SEARCH: if (in_valid && (w != 4'd0)) begin
          pred_d  = seed_next;
          match_d = '0;
          state_d = VERIFY;
        end
        VERIFY: if (in_valid) begin
          if (match) begin
            pred_d  = pred_next;
            match_d = match_inc;
            if (match_inc == LOCK_LIM) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (w == 4'd0) begin
            state_d = SEARCH;
          end else begin
            pred_d  = seed_next;
            match_d = '0;
          end
        end
        LOCKED: if (in_valid) begin
          // Once locked the predictor free-runs; mismatches never reseed it.
          pred_d = pred_next;
          if (match) begin
            miss_d = '0;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (miss_inc == LOSS_LIM) state_d = LOST;
          end
        end
        LOST: begin
          state_d = SEARCH;
          miss_d  = '0;
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_valid   <= 1'b0;
      in_din     <= '0;
      in_mod     <= '0;
      mod_hist   <= '0;
      state      <= SEARCH;
      predictor  <= 4'b0001;
      match_cnt  <= '0;
      miss_run   <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      lost_pulse <= 1'b0;
      err_cnt    <= '0;
    end else begin
      in_valid   <= din_valid;
      in_din     <= din;
      in_mod     <= mod[1:0];
      mod_hist   <= in_mod;
      state      <= state_d;
      predictor  <= pred_d;
      match_cnt  <= match_d;
      miss_run   <= miss_d;
      locked     <= (state_d == LOCKED);
      err_pulse  <= err_d;
      lost_pulse <= (state_d == LOST);
      if (err_d && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef LFSR4_CHECKER_WORDCNT_EN
  logic [15:0] word_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt_q <= '0;
    end else if (!mod_change && (state == LOCKED) && in_valid) begin
      word_cnt_q <= word_cnt_q + 16'd1;
    end
  end

  assign word_cnt = word_cnt_q;
`else
  assign word_cnt = '0;
`endif

endmodule
